// File: rtl/reg_dest_queue_if.sv
// Bus between the decode/issue side and the destination queue.
// The queue is the slave; the control unit / instruction register side is the master.
`timescale 1ns/1ps
interface reg_dest_queue_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [1:0]        sel;
  logic [ADDR_W-1:0] inst20_16;
  logic [ADDR_W-1:0] inst15_11;
  logic              issue;
  logic              retire;
  logic [ADDR_W-1:0] src_a;
  logic [ADDR_W-1:0] src_b;
  logic [ADDR_W-1:0] dest_sel;
  logic [ADDR_W-1:0] wb_dest;
  logic              hazard;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              err;

  modport master (
    output sel, inst20_16, inst15_11, issue, retire, src_a, src_b,
    input  dest_sel, wb_dest, hazard, count, full, empty, err
  );

  modport slave (
    input  sel, inst20_16, inst15_11, issue, retire, src_a, src_b,
    output dest_sel, wb_dest, hazard, count, full, empty, err
  );
endinterface

// File: rtl/reg_dest_queue.sv
// Register-destination selector with an in-order queue of in-flight
// destinations. The oldest entry feeds the register-file write port and
// every pending entry is compared against the decoding sources for RAW hazards.
`timescale 1ns/1ps
module reg_dest_queue #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned LINK_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  reg_dest_queue_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  cnt;
  logic              err_q;

  logic [ADDR_W-1:0] sel_dest;
  logic              is_full;
  logic              is_empty;
  logic              push;
  logic              pop;
  logic              proto_err;
  logic              hit;

  // Destination select; all four codes decode, code 11 means no write.
  always_comb begin
    sel_dest = '0;
    unique case (bus.sel)
      2'b00:   sel_dest = bus.inst20_16;
      2'b01:   sel_dest = bus.inst15_11;
      2'b10:   sel_dest = ADDR_W'(LINK_REG);
      default: sel_dest = '0;
    endcase
  end

  // Push/pop qualification and protocol-error detection.
  // A full queue still accepts a push when a retire frees the head slot on the same edge.
  always_comb begin
    is_full   = (cnt == FULL_CNT);
    is_empty  = (cnt == '0);
    push      = bus.issue && (sel_dest != '0) && (!is_full || bus.retire);
    pop       = bus.retire && !is_empty;
    proto_err = (bus.issue && (sel_dest != '0) && is_full && !bus.retire) ||
                (bus.retire && is_empty);
  end

  // Pointer, occupancy and sticky error state; reset wins over issue/retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (proto_err) err_q <= 1'b1;
    end
  end

  // Entry storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[tail] <= sel_dest;
  end

  // RAW hazard: an entry is valid when its distance from head is below the count.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ({1'b0, PTR_W'(PTR_W'(i) - head)} < cnt) begin
        if (((mem[PTR_W'(i)] == bus.src_a) && (bus.src_a != '0)) ||
            ((mem[PTR_W'(i)] == bus.src_b) && (bus.src_b != '0)))
          hit = 1'b1;
      end
    end
  end

  // Output drive.
  always_comb begin
    bus.dest_sel = sel_dest;
    bus.wb_dest  = is_empty ? '0 : mem[head];
    bus.hazard   = hit;
    bus.count    = cnt;
    bus.full     = is_full;
    bus.empty    = is_empty;
    bus.err      = err_q;
  end
endmodule

// File: doc/reg_dest_queue.md
# reg_dest_queue

Parametrised successor to the MIPS register-destination selector. It selects the write-destination register for each issued instruction from rt, rd or the link register, and queues up to DEPTH in-flight destinations in order. At retire it presents the oldest destination to the register-file write port. Source registers of the decoding instruction are compared against every pending destination to raise a RAW hazard/stall flag. It sits between the control unit / instruction register and the register bank.

## Interface
- ADDR_W, 5, register-address width
- DEPTH, 4, max in-flight destinations (power of two, ≥2)
- LINK_REG, 31, register written by sel = 2'b10 (jal/jalr)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears queue and flags
- sel  in  2  destination select: 00 rt, 01 rd, 10 LINK_REG, 11 no write
- inst20_16  in  ADDR_W  rt field
- inst15_11  in  ADDR_W  rd field
- issue  in  1  push the selected destination this cycle
- retire  in  1  pop the oldest pending destination this cycle
- src_a  in  ADDR_W  rs of the instruction in decode
- src_b  in  ADDR_W  rt of the instruction in decode
- dest_sel  out  ADDR_W  combinational selected destination (0 when sel = 11)
- wb_dest  out  ADDR_W  oldest pending destination; 0 when empty
- hazard  out  1  src_a or src_b matches a pending destination
- count  out  log2(DEPTH)+1  number of pending entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- err  out  1  sticky protocol-error flag

## Operation
- dest_sel: 00→inst20_16, 01→inst15_11, 10→LINK_REG, 11→0. All four codes are defined, so there is no latch inference.
- Push: on issue, if dest_sel ≠ 0 and (not full or retire in the same cycle), dest_sel is written at the tail and the tail pointer advances (mod DEPTH).
  - An issue with dest_sel = 0 is accepted and has no effect. Writes to $zero are never tracked.
- Pop: on retire with count > 0, the head pointer advances (mod DEPTH).
- Simultaneous issue and retire:
  - When non-empty, both take effect and count is unchanged.
  - When full, the push succeeds because the pop frees a slot in the same edge.
  - When empty with a nonzero push, retire is an error. The push still happens, so count becomes 1.
- Errors set err; err stays set until reset. Error cases:
  - Issue while full with no retire: the push is dropped and the queue is unchanged.
  - Retire while empty: ignored.
- hazard = OR over valid entries i of ((entry_i == src_a and src_a ≠ 0) or (entry_i == src_b and src_b ≠ 0)).
  - Valid entries are those between head and tail, using count.
  - hazard is evaluated on the current state. An entry being retired in this cycle still counts.
- wb_dest = entry[head] when count > 0, else 0. It is driven combinationally from storage.
- count, full and empty are derived from registered pointers/count.

## Timing
- Reset values (sampled on a clk edge with reset = 1): count 0, full 0, empty 1, err 0, wb_dest 0, hazard 0, pointers 0. Entry contents are don't-care.
- Reset asserted mid-operation discards all pending entries in that same edge. reset has priority over issue and retire.
- dest_sel has zero latency from sel and the fields.
- Issue into an empty queue: wb_dest, empty and count update on the edge that samples issue. They are visible in the following cycle.
- hazard reflects a newly issued destination from the cycle after the issue edge. There is no same-cycle bypass of the incoming issue.
- Retire: the next entry appears at wb_dest in the cycle after the retire edge.
- Pointer wrap-around at DEPTH must be seamless. FIFO order is preserved across the wrap.

## Test plan
- Select: sel = 00/01/10/11 with inst20_16 = 8, inst15_11 = 12 → dest_sel = 8/12/31/0, same cycle.
- Order and wrap (DEPTH = 4):
  - Issue 5, 6, 7, 9 → full = 1, count = 4.
  - Retire twice, issue 10, 11 → wb_dest sequence 5, 6, 7, then 9, 10, 11 on successive retires.
  - Queue ends empty and err = 0.
- Hazard:
  - Pending {8, 31}, src_a = 31 → hazard = 1.
  - src_a = 0, src_b = 0 → hazard = 0.
  - After 8 and 31 retire, src_b = 8 → hazard = 0 from the cycle after the final retire.
- Zero and boundaries:
  - Issue with sel = 11 → count unchanged, err = 0.
  - Retire on empty → err = 1, count = 0.
  - Issue when full without retire → err = 1, contents unchanged.
- Simultaneous:
  - Full queue, issue 20 + retire in the same cycle → count stays 4, old head is removed, 20 is last out.
  - Empty queue, issue 3 + retire → count = 1, err = 1.
- Reset mid-operation: with 3 pending, assert reset for one edge alongside issue → count = 0, empty = 1, wb_dest = 0, err = 0, hazard = 0.
